// File: rtl/ocx_tlx_vc_rd_arb.sv
// rtl/ocx_tlx_vc_rd_arb.sv - weighted VC0/VC1 read arbiter with 2-entry output buffer
//
// Picks which virtual-channel FIFO to pop each cycle, captures the RAM read
// data one cycle later, and queues it in a 2-entry output FIFO toward the
// parser.
//
// Optional feature: define OCX_TLX_VC_ARB_PERF_EN to add saturating grant
// counters vc0_grant_cnt / vc1_grant_cnt.
//
// Ports:
//   tlx_clk, reset_n           clock, asynchronous active-low reset
//   vc0_req, vc1_req           VC has a verified entry and credit
//   vc0_rd_ena, vc1_rd_ena     one-cycle pop strobes (at most one per cycle)
//   vc0_rd_data, vc1_rd_data   RAM data, valid the cycle after rd_ena
//   cfg_vc1_weight             max consecutive VC1 grants while VC0 waits
//   out_valid/out_ready        output handshake
//   out_vc, out_data           source VC and payload of the oldest entry
//   arb_idle                   nothing in flight, buffer empty, no requests
//   vc0_grant_cnt/vc1_grant_cnt  (PERF_EN only) saturating grant counters
module ocx_tlx_vc_rd_arb #(
    parameter int DATA_WIDTH = 56,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  tlx_clk,
    input  logic                  reset_n,
    input  logic                  vc0_req,
    input  logic                  vc1_req,
    output logic                  vc0_rd_ena,
    output logic                  vc1_rd_ena,
    input  logic [DATA_WIDTH-1:0] vc0_rd_data,
    input  logic [DATA_WIDTH-1:0] vc1_rd_data,
    input  logic [3:0]            cfg_vc1_weight,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_vc,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  arb_idle
`ifdef OCX_TLX_VC_ARB_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  vc0_grant_cnt,
    output logic [CNT_WIDTH-1:0]  vc1_grant_cnt
`endif
);

    logic [3:0]            streak;
    logic                  inflight;
    logic                  inflight_vc;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic                  buf_vc   [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;

    logic       pop;
    logic       push;
    logic [2:0] fill;
    logic       can_grant;
    logic       both_req;
    logic       pick_vc0;
    logic       grant;

    assign pop  = (occ != 2'd0) & out_ready;
    assign push = inflight;

    // Space check counts the read already in flight and credits a pop in
    // the same cycle, so back-to-back grants keep flowing at full rate.
    assign fill      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign can_grant = (fill < 3'd2);

    // '>=' rather than '==' so lowering the weight below the current
    // streak hands the next grant straight to VC0.
    assign both_req = vc0_req & vc1_req;
    assign pick_vc0 = vc0_req & (~vc1_req | (streak >= cfg_vc1_weight));

    // Gated by reset_n so the strobes are quiet throughout reset.
    assign vc0_rd_ena = reset_n & can_grant & pick_vc0;
    assign vc1_rd_ena = reset_n & can_grant & vc1_req & ~pick_vc0;
    assign grant      = vc0_rd_ena | vc1_rd_ena;

    always_ff @(posedge tlx_clk or negedge reset_n) begin
        if (!reset_n) begin
            streak      <= 4'd0;
            inflight    <= 1'b0;
            inflight_vc <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            inflight <= grant;
            if (grant) begin
                inflight_vc <= vc1_rd_ena;
                streak      <= (both_req & vc1_rd_ena) ? streak + 4'd1 : 4'd0;
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy gates every use of it.
    always_ff @(posedge tlx_clk) begin
        if (push) begin
            buf_data[wr_ptr] <= inflight_vc ? vc1_rd_data : vc0_rd_data;
            buf_vc[wr_ptr]   <= inflight_vc;
        end
    end

    assign out_valid = (occ != 2'd0);
    assign out_vc    = out_valid & buf_vc[rd_ptr];
    assign out_data  = out_valid ? buf_data[rd_ptr] : '0;
    assign arb_idle  = ~reset_n |
                       (~inflight & (occ == 2'd0) & ~vc0_req & ~vc1_req);

`ifdef OCX_TLX_VC_ARB_PERF_EN
    always_ff @(posedge tlx_clk or negedge reset_n) begin
        if (!reset_n) begin
            vc0_grant_cnt <= '0;
            vc1_grant_cnt <= '0;
        end else begin
            if (vc0_rd_ena && !(&vc0_grant_cnt)) begin
                vc0_grant_cnt <= vc0_grant_cnt + CNT_WIDTH'(1);
            end
            if (vc1_rd_ena && !(&vc1_grant_cnt)) begin
                vc1_grant_cnt <= vc1_grant_cnt + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule
